// File: rtl/mc_data_path_pkg.sv
// Shared types, opcode/ALU encodings and the combinational ALU and immediate
// generator used by the multi-cycle RV32 datapath.
package mc_data_path_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    function automatic logic [31:0] alu_32(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0]  cc);
        logic [31:0] y;
        case (cc)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_SLTU: y = {31'b0, a < b};
            ALU_NOR:  y = ~(a | b);
            default:  y = '0;
        endcase
        return y;
    endfunction

    // B-type immediates are byte offsets with an implicit zero LSB.
    function automatic logic [31:0] imm_gen(input logic [31:0] ins);
        logic [31:0] imm;
        case (ins[6:0])
            OP_I, OP_LOAD: imm = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:      imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:     imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default:       imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_data_path_regfile.sv
// Register file: 2**RF_ADDRESS x DATA_W, x0 hard-wired to zero, cleared by reset.
module mc_regfile #(
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [RF_ADDRESS-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [RF_ADDRESS-1:0] raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic [RF_ADDRESS-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata2
);
    localparam int NREG = 2 ** RF_ADDRESS;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/mc_data_path.sv
// Multi-cycle RV32 datapath: BOOT/FETCH/DECODE/EXEC/MEM/WB sequencing with
// req/valid instruction and data memory handshakes; control comes from outside.
module mc_data_path
    import mc_data_path_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter int              INS_W      = 32,
    parameter int              DATA_W     = 32,
    parameter int              RF_ADDRESS = 5,
    parameter int              DM_ADDRESS = 9,
    parameter int              ALU_CC_W   = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic                  mem2reg,
    input  logic                  alu_src,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic                  branch,
    input  logic [ALU_CC_W-1:0]   alu_cc,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INS_W-1:0]      imem_rdata,
    input  logic                  imem_valid,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DM_ADDRESS-1:0] dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_valid,
    output logic [6:0]            opcode,
    output logic [6:0]            funct7,
    output logic [2:0]            funct3,
    output logic [DATA_W-1:0]     alu_result,
    output logic [PC_W-1:0]       pc,
    output logic                  retire
);
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INS_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_W-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
    logic              z_q, z_d;

    logic [DATA_W-1:0] rs1_data, rs2_data, alu_y, rf_wdata;
    logic              alu_zero, rf_we, take_branch;

    mc_regfile #(.DATA_W(DATA_W), .RF_ADDRESS(RF_ADDRESS)) u_rf (
        .clk    (clk),
        .rst_n  (reset),
        .we     (rf_we),
        .waddr  (ir_q[7 +: RF_ADDRESS]),
        .wdata  (rf_wdata),
        .raddr1 (ir_q[15 +: RF_ADDRESS]),
        .rdata1 (rs1_data),
        .raddr2 (ir_q[20 +: RF_ADDRESS]),
        .rdata2 (rs2_data)
    );

    assign alu_y    = alu_32(a_q, alu_src ? imm_q : b_q, alu_cc);
    assign alu_zero = (alu_y == '0);
    assign rf_wdata = mem2reg ? mdr_q : aluout_q;
    // Branches retire in EXEC, so the flag being captured this cycle is the one used.
    assign take_branch = branch & ((state_q == ST_EXEC) ? alu_zero : z_q);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        aluout_d = aluout_q;
        z_d      = z_q;
        mdr_d    = mdr_q;
        retire   = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = rs1_data;
                b_d     = rs2_data;
                imm_d   = imm_gen(ir_q);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                aluout_d = alu_y;
                z_d      = alu_zero;
                if (mem_read | mem_write) begin
                    state_d = ST_MEM;
                end else if (reg_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                if (dmem_valid) begin
                    if (mem_write) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = reg_write;
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: state_d = ST_BOOT;
        endcase
        if (retire) begin
            pc_d = take_branch ? pc_q + imm_q[PC_W-1:0] : pc_q + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            aluout_q <= '0;
            z_q      <= 1'b0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            aluout_q <= aluout_d;
            z_q      <= z_d;
            mdr_q    <= mdr_d;
        end
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = dmem_req & mem_write;
    assign dmem_addr  = aluout_q[DM_ADDRESS-1:0];
    assign dmem_wdata = b_q;
    assign opcode     = ir_q[6:0];
    assign funct7     = ir_q[31:25];
    assign funct3     = ir_q[14:12];
    assign alu_result = aluout_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_mc_data_path.sv
// Scoreboard bench for mc_data_path: directed program, memory responders with
// wait states and spurious valids, monitor checks each retire and data access.
module tb_mc_data_path;
    import mc_data_path_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write, mem2reg, alu_src, mem_write, mem_read, branch;
    logic [3:0]  alu_cc;
    logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_valid, retire;
    logic [9:0]  imem_addr, pc;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, alu_result;
    logic [8:0]  dmem_addr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    always #5 clk = ~clk;

    mc_data_path dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .mem2reg(mem2reg),
        .alu_src(alu_src), .mem_write(mem_write), .mem_read(mem_read),
        .branch(branch), .alu_cc(alu_cc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .opcode(opcode), .funct7(funct7), .funct3(funct3),
        .alu_result(alu_result), .pc(pc), .retire(retire)
    );

    typedef struct {logic [31:0] alu; logic [9:0] pc; logic [6:0] op; int cyc;} ret_t;
    typedef struct {logic we; logic [8:0] addr; logic [31:0] wdata; int cnt;} dm_t;

    ret_t        exp_q[$];
    dm_t         dq[$];
    logic [31:0] imem_arr [256];
    logic [31:0] dmem_arr [128];
    int          lat_tab  [256];
    int          n_vec = 0, n_err = 0, retire_seen = 0;
    logic        hold = 1'b0;
    logic        pc_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    task automatic push_ret(input logic [31:0] alu, input logic [9:0] npc,
                            input logic [6:0] op, input int cyc);
        ret_t r;
        r.alu = alu; r.pc = npc; r.op = op; r.cyc = cyc;
        exp_q.push_back(r);
    endtask
    task automatic push_dm(input logic we, input logic [8:0] addr,
                           input logic [31:0] wdata, input int cnt);
        dm_t d;
        d.we = we; d.addr = addr; d.wdata = wdata; d.cnt = cnt;
        dq.push_back(d);
    endtask

    // Memory responders and external controller; valids outside a request are garbage.
    initial begin
        int dwait;
        dwait = 0;
        imem_valid = 1'b0; imem_rdata = '0; dmem_valid = 1'b0; dmem_rdata = '0;
        {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = '0;
        alu_cc = ALU_ADD;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                imem_valid = !(hold && imem_addr == 10'h004);
                imem_rdata = imem_arr[imem_addr[9:2]];
            end else begin
                imem_valid = 1'b1;
                imem_rdata = 32'hFFFF_FFFF;
            end
            if (dmem_req) begin
                if (dwait >= lat_tab[pc[9:2]]) begin
                    dmem_valid = 1'b1;
                    dmem_rdata = dmem_arr[dmem_addr[8:2]];
                    if (dmem_we) dmem_arr[dmem_addr[8:2]] = dmem_wdata;
                end else begin
                    dmem_valid = 1'b0;
                end
                dwait++;
            end else begin
                dwait = 0;
                dmem_valid = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = '0;
            alu_cc = ALU_ADD;
            case (opcode)
                OP_R: begin
                    reg_write = 1'b1;
                    case (funct3)
                        3'd0:    alu_cc = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'd2:    alu_cc = ALU_SLT;
                        3'd4:    alu_cc = ALU_XOR;
                        3'd6:    alu_cc = ALU_OR;
                        3'd7:    alu_cc = ALU_AND;
                        default: alu_cc = ALU_ADD;
                    endcase
                end
                OP_I:      begin reg_write = 1'b1; alu_src = 1'b1; end
                OP_LOAD:   begin reg_write = 1'b1; mem2reg = 1'b1; mem_read = 1'b1; alu_src = 1'b1; end
                OP_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; end
                OP_BRANCH: begin branch = 1'b1; alu_cc = ALU_SUB; end
                default:   ;
            endcase
        end
    end

    // Monitor: retire results appear in pc/alu_result on the following cycle.
    initial begin
        ret_t        cur;
        dm_t         dexp;
        int          cyc, dcnt;
        logic        dbad, dwe0;
        logic [8:0]  daddr0;
        logic [31:0] dwd0;
        cyc = 0; dcnt = 0; dbad = 1'b0; dwe0 = 1'b0; daddr0 = '0; dwd0 = '0;
        cur = '{alu: '0, pc: '0, op: '0, cyc: 0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                cyc = 0; dcnt = 0; dbad = 1'b0;
                continue;
            end
            if (pc_pending) begin
                check("next_pc", 32'(pc), 32'(cur.pc));
                check("alu_result", alu_result, cur.alu);
                pc_pending = 1'b0;
            end
            cyc++;
            if (dmem_req) begin
                if (dcnt == 0) begin
                    dwe0 = dmem_we; daddr0 = dmem_addr; dwd0 = dmem_wdata;
                end else if (dmem_we !== dwe0 || dmem_addr !== daddr0 || dmem_wdata !== dwd0) begin
                    dbad = 1'b1;
                end
                dcnt++;
                if (dmem_valid) begin
                    if (dq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL dmem_unexpected addr=%h", dmem_addr);
                    end else begin
                        dexp = dq.pop_front();
                        check("dmem_we", 32'(dmem_we), 32'(dexp.we));
                        check("dmem_addr", 32'(dmem_addr), 32'(dexp.addr));
                        check("dmem_wdata", dmem_wdata, dexp.wdata);
                        check("dmem_req_cycles", 32'(dcnt), 32'(dexp.cnt));
                        check("dmem_stable", 32'(dbad), 32'd0);
                    end
                    dcnt = 0; dbad = 1'b0;
                end
            end
            if (retire) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL retire_unexpected pc=%h", pc);
                end else begin
                    cur = exp_q.pop_front();
                    check("retire_opcode", 32'(opcode), 32'(cur.op));
                    check("retire_cycles", 32'(cyc), 32'(cur.cyc));
                    pc_pending = 1'b1;
                    retire_seen++;
                end
                cyc = 0;
            end
        end
    end

    initial begin
        logic done;
        for (int i = 0; i < 256; i++) begin imem_arr[i] = '0; lat_tab[i] = 0; end
        for (int i = 0; i < 128; i++) dmem_arr[i] = '0;
        imem_arr[0]   = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I);        // addi x1,x0,5
        imem_arr[1]   = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);         // add  x2,x1,x1
        imem_arr[2]   = enc_s(12'd0, 5'd2, 5'd0, 3'd2);               // sw   x2,0(x0)
        imem_arr[3]   = enc_i(12'd0, 5'd0, 3'd2, 5'd3, OP_LOAD);     // lw   x3,0(x0)
        imem_arr[4]   = enc_b(13'h00C, 5'd1, 5'd1, 3'd0);             // beq  x1,x1,+12
        imem_arr[7]   = enc_b(13'h00C, 5'd2, 5'd1, 3'd0);             // beq  x1,x2,+12
        imem_arr[8]   = enc_s(12'd4, 5'd3, 5'd0, 3'd2);               // sw   x3,4(x0)
        imem_arr[9]   = enc_i(12'd7, 5'd0, 3'd0, 5'd0, OP_I);        // addi x0,x0,7
        imem_arr[10]  = enc_s(12'd8, 5'd0, 5'd0, 3'd2);               // sw   x0,8(x0)
        imem_arr[11]  = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd4);         // add  x4,x2,x3
        imem_arr[12]  = enc_b(13'h1FCC, 5'd0, 5'd0, 3'd0);            // beq  x0,x0,-52
        imem_arr[255] = enc_i(12'd1, 5'd4, 3'd0, 5'd5, OP_I);        // addi x5,x4,1
        lat_tab[2] = 3;

        push_ret(32'd5,          10'h004, OP_I,      5);
        push_ret(32'd10,         10'h008, OP_R,      4);
        push_ret(32'd0,          10'h00C, OP_STORE,  7);
        push_ret(32'd0,          10'h010, OP_LOAD,   5);
        push_ret(32'd0,          10'h01C, OP_BRANCH, 3);
        push_ret(32'hFFFF_FFFB,  10'h020, OP_BRANCH, 3);
        push_ret(32'd4,          10'h024, OP_STORE,  4);
        push_ret(32'd7,          10'h028, OP_I,      4);
        push_ret(32'd8,          10'h02C, OP_STORE,  4);
        push_ret(32'd20,         10'h030, OP_R,      4);
        push_ret(32'd0,          10'h3FC, OP_BRANCH, 3);
        push_ret(32'd21,         10'h000, OP_I,      4);
        push_ret(32'd5,          10'h004, OP_I,      4);
        push_dm(1'b1, 9'h000, 32'd10, 4);
        push_dm(1'b0, 9'h000, 32'd0,  1);
        push_dm(1'b1, 9'h004, 32'd10, 1);
        push_dm(1'b1, 9'h008, 32'd0,  1);

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_dmem_req", 32'(dmem_req), 32'd0);
        check("reset_retire", 32'(retire), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            if (retire_seen >= 2) hold = 1'b1;
            done = (exp_q.size() == 0) && (dq.size() == 0) && !pc_pending;
        end
        check("program_drained", 32'(done), 32'd1);

        @(posedge clk); #3;
        check("fetch_wait_req", 32'(imem_req), 32'd1);
        check("fetch_wait_addr", 32'(imem_addr), 32'h004);
        repeat (2) @(posedge clk); #3;
        check("fetch_wait_addr_held", 32'(imem_addr), 32'h004);

        reset = 1'b0;
        #1;
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_imem_req", 32'(imem_req), 32'd0);
        check("abort_retire", 32'(retire), 32'd0);
        check("abort_alu_result", alu_result, 32'd0);
        repeat (2) @(posedge clk); #3;
        check("abort_hold_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1; hold = 1'b0;
        @(negedge clk); #1;
        check("boot_idle_req", 32'(imem_req), 32'd0);
        @(negedge clk); #1;
        check("boot_fetch_req", 32'(imem_req), 32'd1);
        check("boot_fetch_addr", 32'(imem_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
